// File: rtl/aes_pkg.sv
// Shared AES round-datapath definitions: state geometry, GF(2^8) reduction
// constant, MixColumns FSM encoding and the xtime helper.
package aes_pkg;

    localparam int         AES_STATE_W    = 128;
    localparam int         AES_COLS       = 4;
    localparam logic [7:0] AES_XTIME_POLY = 8'h1B;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_COL  = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/gf_mul2.sv
// Four-lane GF(2^8) multiply-by-2 unit; one byte lane per column byte,
// most significant byte is lane 0.
module gf_mul2
    import aes_pkg::*;
(
    input  logic [31:0] a_i,
    output logic [31:0] m_o
);

    assign m_o[31:24] = xtime(a_i[31:24]);
    assign m_o[23:16] = xtime(a_i[23:16]);
    assign m_o[15:8]  = xtime(a_i[15:8]);
    assign m_o[7:0]   = xtime(a_i[7:0]);

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: one column per cycle through a shared xtime unit,
// with an optional last-round bypass that returns the state unmixed.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter bit USE_BYPASS = 1'b1
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
);

    mc_state_e              state_q, state_d;
    logic [1:0]             col_q, col_d;
    logic [AES_STATE_W-1:0] data_q, data_d;

    logic [31:0] col_word_s;
    logic [31:0] col_x2_s;
    logic [31:0] col_mixed_s;
    logic [7:0]  a0_s, a1_s, a2_s, a3_s;
    logic [7:0]  m0_s, m1_s, m2_s, m3_s;

    // Select the column currently being mixed; column 0 sits in the top word.
    always_comb begin
        col_word_s = data_q[127:96];
        case (col_q)
            2'd0:    col_word_s = data_q[127:96];
            2'd1:    col_word_s = data_q[95:64];
            2'd2:    col_word_s = data_q[63:32];
            2'd3:    col_word_s = data_q[31:0];
            default: col_word_s = data_q[127:96];
        endcase
    end

    gf_mul2 u_gf_mul2 (
        .a_i (col_word_s),
        .m_o (col_x2_s)
    );

    assign {a0_s, a1_s, a2_s, a3_s} = col_word_s;
    assign {m0_s, m1_s, m2_s, m3_s} = col_x2_s;

    // Circulant {2,3,1,1}: 3*a is formed as xtime(a) ^ a.
    assign col_mixed_s[31:24] = m0_s ^ m1_s ^ a1_s ^ a2_s ^ a3_s;
    assign col_mixed_s[23:16] = a0_s ^ m1_s ^ m2_s ^ a2_s ^ a3_s;
    assign col_mixed_s[15:8]  = a0_s ^ a1_s ^ m2_s ^ m3_s ^ a3_s;
    assign col_mixed_s[7:0]   = m0_s ^ a0_s ^ a1_s ^ a2_s ^ m3_s;

    // Next-state, column counter and working-register update.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        data_d  = data_q;
        if (abort) begin
            // Abort wins over any handshake and leaves the data register alone.
            state_d = MC_IDLE;
        end else begin
            case (state_q)
                MC_IDLE: begin
                    if (in_valid) begin
                        data_d = in_data;
                        col_d  = 2'd0;
                        if (in_last && USE_BYPASS) begin
                            state_d = MC_DONE;
                        end else begin
                            state_d = MC_COL;
                        end
                    end else begin
                        state_d = MC_IDLE;
                    end
                end
                MC_COL: begin
                    case (col_q)
                        2'd0:    data_d[127:96] = col_mixed_s;
                        2'd1:    data_d[95:64]  = col_mixed_s;
                        2'd2:    data_d[63:32]  = col_mixed_s;
                        2'd3:    data_d[31:0]   = col_mixed_s;
                        default: data_d         = data_q;
                    endcase
                    col_d = col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        state_d = MC_DONE;
                    end else begin
                        state_d = MC_COL;
                    end
                end
                MC_DONE: begin
                    if (out_ready) begin
                        state_d = MC_IDLE;
                    end else begin
                        state_d = MC_DONE;
                    end
                end
                default: begin
                    state_d = MC_IDLE;
                end
            endcase
        end
    end

    // State, counter and working register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MC_IDLE;
            col_q   <= 2'd0;
            data_q  <= {AES_STATE_W{1'b0}};
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = (state_q == MC_IDLE);
    assign out_valid = (state_q == MC_DONE);
    assign busy      = (state_q == MC_COL) || (state_q == MC_DONE);
    assign out_data  = data_q;

endmodule
